// File: rtl/bus_sram_pkg.sv
// rtl/bus_sram_pkg.sv - shared types and constants for the bus SRAM responder
package bus_sram_pkg;

    localparam int BURST_LEN_W    = 3;
    localparam int MAX_RD_LATENCY = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_STALL    = 2'd3
    } state_t;

endpackage

// File: rtl/sram_be.sv
// rtl/sram_be.sv - single-port synchronous RAM with byte-write mask, write-first
//   clk   : clock
//   en    : port enable (read or write this cycle)
//   we    : write enable, qualified per byte by be
//   addr  : word address
//   wdata : write data
//   be    : byte enables, bit i -> wdata[8i+7:8i]
//   rdata : registered read data, one cycle after en
module sram_be #(
    parameter int ADDR_W = 12,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   be,
    output logic [DW-1:0]     rdata
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem [2**ADDR_W];

    // Per-byte write-first template so the tools map it onto byte-write block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    rdata[8*i +: 8]     <= wdata[8*i +: 8];
                end else begin
                    rdata[8*i +: 8]     <= mem[addr][8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - on-chip RAM standing in for the SDRAM on the system bus
//   bus_read/bus_write : requests, held until bus_ready
//   bus_addr           : word address (burst start address)
//   bus_burst/_len     : burst request, beats minus one
//   bus_wdata/_byteenable : write data and per-byte enables
//   bus_ready          : request/beat accepted when high (registered state only)
//   bus_rvalid/_rdata  : read returns, RD_LATENCY cycles after accept, in order
module bus_sram_responder
    import bus_sram_pkg::*;
#(
    parameter int AW           = 23,
    parameter int DW           = 16,
    parameter int MEM_AW       = 12,
    parameter int RD_LATENCY   = 3,
    parameter int STALL_PERIOD = 0,
    parameter int STALL_LEN    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bus_read,
    input  logic                   bus_write,
    input  logic [AW-1:0]          bus_addr,
    input  logic                   bus_burst,
    input  logic [BURST_LEN_W-1:0] bus_burst_len,
    input  logic [DW-1:0]          bus_wdata,
    input  logic [DW/8-1:0]        bus_byteenable,
    output logic                   bus_ready,
    output logic                   bus_rvalid,
    output logic [DW-1:0]          bus_rdata
);

    localparam int SPW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int SLW = (STALL_LEN > 1) ? $clog2(STALL_LEN) : 1;

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("bus_sram_responder: RD_LATENCY out of range");
    end

    state_t                 state, state_d;
    logic [BURST_LEN_W-1:0] beat_cnt, beat_cnt_d;
    logic [MEM_AW-1:0]      addr_q, addr_d;
    logic [SPW-1:0]         period_cnt;
    logic [SLW-1:0]         stall_cnt, stall_cnt_d;
    logic                   stall_pending, stall_tick, stall_clr;
    logic                   ram_en, ram_we, issue;
    logic [MEM_AW-1:0]      ram_addr;
    logic [DW-1:0]          ram_rdata;
    logic [RD_LATENCY-1:0]  vld_q;
    logic [DW-1:0]          out_data, rdata_hold;
    logic                   unused_addr_hi;

    // Upper address bits alias onto the implemented depth.
    assign unused_addr_hi = ^bus_addr[AW-1:MEM_AW];

    assign bus_ready = (state == ST_IDLE && !stall_pending) || (state == ST_WR_BURST);

    always_comb begin
        state_d     = state;
        beat_cnt_d  = beat_cnt;
        addr_d      = addr_q;
        stall_cnt_d = stall_cnt;
        stall_clr   = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_q;
        issue       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stall_pending) begin
                    // The IDLE cycle with pending already counts as the first low cycle.
                    if (STALL_LEN > 1) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = SLW'(STALL_LEN - 2);
                    end else begin
                        stall_clr = 1'b1;
                    end
                end else if (bus_write) begin
                    // A simultaneous read is dropped; the write wins.
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = bus_addr[MEM_AW-1:0];
                    if (bus_burst && bus_burst_len != '0) begin
                        state_d    = ST_WR_BURST;
                        beat_cnt_d = bus_burst_len;
                        addr_d     = bus_addr[MEM_AW-1:0] + 1'b1;
                    end
                end else if (bus_read) begin
                    ram_en   = 1'b1;
                    ram_addr = bus_addr[MEM_AW-1:0];
                    issue    = 1'b1;
                    if (bus_burst && bus_burst_len != '0) begin
                        state_d    = ST_RD_BURST;
                        beat_cnt_d = bus_burst_len;
                        addr_d     = bus_addr[MEM_AW-1:0] + 1'b1;
                    end
                end
            end
            ST_WR_BURST: begin
                if (bus_write) begin
                    ram_en     = 1'b1;
                    ram_we     = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    beat_cnt_d = beat_cnt - 1'b1;
                    if (beat_cnt == BURST_LEN_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                ram_en     = 1'b1;
                issue      = 1'b1;
                addr_d     = addr_q + 1'b1;
                beat_cnt_d = beat_cnt - 1'b1;
                if (beat_cnt == BURST_LEN_W'(1)) state_d = ST_IDLE;
            end
            ST_STALL: begin
                if (stall_cnt == '0) begin
                    state_d   = ST_IDLE;
                    stall_clr = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall_tick = (STALL_PERIOD != 0) && (period_cnt == SPW'(STALL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            addr_q        <= '0;
            stall_cnt     <= '0;
            period_cnt    <= '0;
            stall_pending <= 1'b0;
        end else begin
            state     <= state_d;
            beat_cnt  <= beat_cnt_d;
            addr_q    <= addr_d;
            stall_cnt <= stall_cnt_d;
            if (STALL_PERIOD != 0) period_cnt <= stall_tick ? '0 : period_cnt + 1'b1;
            if (stall_tick)     stall_pending <= 1'b1;
            else if (stall_clr) stall_pending <= 1'b0;
        end
    end

    sram_be #(.ADDR_W(MEM_AW), .DW(DW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus_wdata),
        .be    (bus_byteenable),
        .rdata (ram_rdata)
    );

    // vld_q[0] lines up with the RAM output; vld_q[i] with register stage i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    if (RD_LATENCY > 1) begin : g_pipe
        logic [DW-1:0] dat_q [RD_LATENCY-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RD_LATENCY-1; i++) dat_q[i] <= '0;
            end else begin
                if (vld_q[0]) dat_q[0] <= ram_rdata;
                for (int i = 1; i < RD_LATENCY-1; i++) begin
                    if (vld_q[i]) dat_q[i] <= dat_q[i-1];
                end
            end
        end
        assign out_data = dat_q[RD_LATENCY-2];
    end else begin : g_nopipe
        assign out_data = ram_rdata;
    end

    // The RAM output moves on writes, so the last returned word is kept separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rdata_hold <= '0;
        else if (bus_rvalid) rdata_hold <= out_data;
    end

    assign bus_rvalid = vld_q[RD_LATENCY-1];
    assign bus_rdata  = bus_rvalid ? out_data : rdata_hold;

    always @(posedge clk) begin
        if (rst_n && state == ST_IDLE && !stall_pending)
            assert (!(bus_read && bus_write))
                else $error("bus_sram_responder: bus_read and bus_write asserted together");
    end

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

On-chip RAM responder for the system bus that the SDRAM controller serves, built as the far end of that protocol from the JTAG host. It accepts single and burst reads/writes with the same handshake as the SDRAM controller and returns read data after a fixed, parameterised latency. It can also periodically deassert ready to emulate refresh. It stands in for the SDRAM on boards and benches, so host and traffic logic can be brought up against a deterministic golden memory.

## Interface
- AW, 23, bus address width in 16-bit words
- DW, 16, data width; multiple of 8
- MEM_AW, 12, implemented RAM depth is 2^MEM_AW words; upper address bits ignored (aliased)
- RD_LATENCY, 3, cycles from read accept to first rvalid; legal 1..8
- STALL_PERIOD, 0, refresh-emulation period in cycles; 0 disables stalls
- STALL_LEN, 4, cycles bus_ready is held low per stall; ≥1
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- bus_read  in  1  read request, held until accepted
- bus_write  in  1  write request / write beat, held until accepted
- bus_addr  in  AW  word address (start address for bursts)
- bus_burst  in  1  request is a burst
- bus_burst_len  in  3  burst beats minus one (0..7 → 1..8 beats)
- bus_wdata  in  DW  write data
- bus_byteenable  in  DW/8  per-byte write enable, bit i → bits [8i+7:8i]
- bus_ready  out  1  request/beat accepted this cycle when high
- bus_rvalid  out  1  read data valid, one beat per cycle
- bus_rdata  out  DW  read data

## Operation
- Accept = (bus_read | bus_write) & bus_ready in the same cycle.
- States: IDLE, WR_BURST, RD_BURST, STALL.
- bus_ready = (IDLE & !stall_pending) | WR_BURST. It depends only on registered state, never on inputs.
- IDLE, write accepted: beat 0 is written at bus_addr with byteenable.
  - If bus_burst and len>0: load beat counter = len, go to WR_BURST.
- WR_BURST: each cycle with bus_write high writes the next beat at address+1 and decrements the counter.
  - Cycles with bus_write low wait.
  - bus_read is ignored.
  - Return to IDLE after the last beat.
- IDLE, read accepted: issue a RAM read at bus_addr.
  - If bus_burst and len>0: go to RD_BURST and issue one read per cycle for the remaining beats. bus_ready is low throughout; return to IDLE after the last issue.
- Single reads in IDLE may be accepted every cycle and pipeline fully.
- Burst addresses increment linearly and wrap modulo 2^MEM_AW.
- Read data is written into a valid/data pipeline of total depth RD_LATENCY: the RAM's synchronous read counts as 1 stage, plus RD_LATENCY-1 register stages. Returns stay in order.
- Stall: a free-running counter sets stall_pending every STALL_PERIOD cycles.
  - Pending is serviced only in IDLE, so bursts are never interrupted: IDLE→STALL for STALL_LEN cycles→IDLE, then pending clears.
  - The read pipeline keeps draining during STALL.
- bus_read and bus_write both high in IDLE is a protocol violation: the write is performed, the read is dropped, and a simulation assertion fires.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.

## Timing
- Reset values: state IDLE, bus_ready 1, bus_rvalid 0, bus_rdata 0, stall counter 0, pending 0. RAM contents are not reset.
- Single read accepted at cycle t → bus_rvalid at t+RD_LATENCY.
- Burst read of N beats accepted at t → bus_ready low t+1..t+N-1, bus_rvalid t+L..t+L+N-1, contiguous.
- Writes take effect at the accept edge; there is no write response.
- Reset asserted mid-burst or with reads in flight: the pipeline clears immediately and no further rvalid appears; IDLE on release.
- bus_rdata holds its last value when bus_rvalid is low.

## Structure
- Package bus_sram_pkg: state enum, burst-length width constant, max RD_LATENCY constant.
- Sub-module sram_be: single-port synchronous RAM, 2^MEM_AW × DW, byte-write mask, 1-cycle read, write-first. It must infer block RAM.
- Top holds the FSM, beat counter, address counter, stall counter and latency pipeline.

## Test plan
- Reset release → bus_ready=1, bus_rvalid=0; write 0x0010←0xA5A5 (be 11), then read 0x0010 → rvalid exactly 3 cycles after accept, rdata 0xA5A5.
- Write 0x0020←0x1234, then write 0xFFFF with be 01, then read → 0x12FF.
- Burst write len=3 at 0x0100 with data 1,2,3,4 (one idle gap between beats 2 and 3), then burst read len=3 → bus_ready low 3 cycles after accept; rvalid on 4 consecutive cycles carrying 1,2,3,4.
- Eight back-to-back single reads 0x0100..0x0107 → accepted on 8 consecutive cycles; 8 consecutive rvalids in order.
- STALL_PERIOD=64, STALL_LEN=4 → bus_ready low exactly 4 cycles per 64 when idle; a read held during a stall is accepted on the first ready cycle; a burst in progress delays the stall until it completes.
- MEM_AW=12: write 0x1005←0xBEEF, read 0x0005 → 0xBEEF. Then rst_n low after 2 of 4 burst-read rvalids → no further rvalid; bus_ready=1 after release.
